// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and constants for the write-address slave slice.
//   prot_t          : 3-bit AxPROT attribute bundle
//   AXIL_RESP_*     : BRESP/RRESP encodings
//   AXIL_WORD_MASK  : low address bits cleared to form a 32-bit word address
//   axil_resp_for() : response code for an entry given its decode-error flag
package axil_pkg;

    typedef logic [2:0] prot_t;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXIL_WORD_MASK = 2'b11;

    // Entries flagged as out of range are answered with DECERR downstream.
    function automatic logic [1:0] axil_resp_for(input logic addr_err);
        return addr_err ? AXIL_RESP_DECERR : AXIL_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
//   ACLK, ARESETn : clock, asynchronous active-low reset
//   wr_en/wr_data : push request; ignored while full
//   rd_en         : pop request; ignored while empty
//   rd_data       : head entry, forced to 0 while empty
//   rd_valid      : queue non-empty
//   full          : count == DEPTH
//   count         : occupancy 0..DEPTH
module axil_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    assign full     = (count_reg == FULL_COUNT);
    assign rd_valid = (count_reg != '0);
    assign push     = wr_en && !full;
    assign pop      = rd_en && rd_valid;

    // Head is read combinationally; zeroed while empty so reset shows 0.
    assign rd_data = rd_valid ? mem_reg[rd_ptr_reg] : '0;
    assign count   = count_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/axil_aw_slave_fifo.sv
// AXI4-Lite write-address channel slave with a DEPTH-entry FWFT queue.
// Accepted addresses are word-aligned and queued with AWPROT (and, when
// AXIL_AW_RANGE_CHECK_EN is defined, a per-entry out-of-window flag).
//   ACLK, ARESETn          : clock, asynchronous active-low reset
//   AWVALID/AWADDR/AWPROT  : master address channel inputs
//   AWREADY                : slave ready, from registered state only
//   o_addr_valid/o_addr/o_prot/o_addr_err : queue head
//   i_addr_ready           : consumer pop strobe
//   o_count                : queue occupancy
// Optional feature macro: AXIL_AW_RANGE_CHECK_EN (range check on push).
module axil_aw_slave_fifo
    import axil_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [ADDR_WIDTH:0]   RANGE_SIZE = 'h1000
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    AWVALID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]              AWPROT,
    output logic                    AWREADY,
    output logic                    o_addr_valid,
    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic [2:0]              o_prot,
    output logic                    o_addr_err,
    input  logic                    i_addr_ready,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK_EXT = ADDR_WIDTH'(AXIL_WORD_MASK);
`ifdef AXIL_AW_RANGE_CHECK_EN
    localparam int ENTRY_W = ADDR_WIDTH + 3 + 1;
`else
    localparam int ENTRY_W = ADDR_WIDTH + 3;
`endif

    // Elaboration-time parameter legality checks.
    if (ADDR_WIDTH < 12 || ADDR_WIDTH > 64) begin : g_bad_addr_width
        $error("ADDR_WIDTH must be in 12..64");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 2");
    end
    if (RANGE_SIZE == '0 || (RANGE_SIZE & (RANGE_SIZE - 1'b1)) != '0) begin : g_bad_range
        $error("RANGE_SIZE must be a non-zero power of two");
    end
    if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
        $error("BASE_ADDR must be word aligned");
    end

    logic               rst_done_reg;
    logic               push;
    logic               fifo_full;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    prot_t              head_prot;

    // AWREADY rises one edge after reset release, then tracks space only.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) rst_done_reg <= 1'b0;
        else          rst_done_reg <= 1'b1;
    end

    assign AWREADY = rst_done_reg && !fifo_full;
    assign push    = AWVALID && AWREADY;

`ifdef AXIL_AW_RANGE_CHECK_EN
    logic [ADDR_WIDTH-1:0] addr_offset;
    logic                  push_err;

    // Wrapping subtraction: addresses below BASE_ADDR land far above the window.
    assign addr_offset = AWADDR - BASE_ADDR;
    assign push_err    = ({1'b0, addr_offset} >= RANGE_SIZE);
    assign push_entry  = {push_err, AWPROT, AWADDR & ~WORD_MASK_EXT};
    assign o_addr_err  = head_entry[ENTRY_W-1];
`else
    assign push_entry  = {AWPROT, AWADDR & ~WORD_MASK_EXT};
    assign o_addr_err  = 1'b0;
`endif

    assign head_prot = head_entry[ADDR_WIDTH +: 3];
    assign o_prot    = head_prot;
    assign o_addr    = head_entry[ADDR_WIDTH-1:0];

    axil_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .wr_en    (push),
        .wr_data  (push_entry),
        .rd_en    (i_addr_ready),
        .rd_data  (head_entry),
        .rd_valid (o_addr_valid),
        .full     (fifo_full),
        .count    (o_count)
    );

endmodule

// File: tb/tb_axil_aw_slave_fifo.sv
module tb_axil_aw_slave_fifo;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
`ifdef AXIL_AW_RANGE_CHECK_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    logic          ACLK = 1'b0;
    logic          ARESETn = 1'b0;
    logic          AWVALID = 1'b0;
    logic [AW-1:0] AWADDR = '0;
    logic [2:0]    AWPROT = '0;
    logic          AWREADY;
    logic          o_addr_valid;
    logic [AW-1:0] o_addr;
    logic [2:0]    o_prot;
    logic          o_addr_err;
    logic          i_addr_ready = 1'b0;
    logic [2:0]    o_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 ACLK = ~ACLK;

    axil_aw_slave_fifo #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .BASE_ADDR  (32'h0000_1000),
        .RANGE_SIZE (33'h0_0000_1000)
    ) dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .AWVALID      (AWVALID),
        .AWADDR       (AWADDR),
        .AWPROT       (AWPROT),
        .AWREADY      (AWREADY),
        .o_addr_valid (o_addr_valid),
        .o_addr       (o_addr),
        .o_prot       (o_prot),
        .o_addr_err   (o_addr_err),
        .i_addr_ready (i_addr_ready),
        .o_count      (o_count)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        vectors++;
        if ({AWREADY, o_addr_valid, o_count, o_addr, o_prot, o_addr_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got rdy=%b v=%b cnt=%0d addr=%h prot=%0d err=%b, want all 0",
                     AWREADY, o_addr_valid, o_count, o_addr, o_prot, o_addr_err);
        end
        ARESETn = 1'b1;
        #1;
        vectors++;
        if (AWREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_ready_low: got %b want 0", AWREADY);
        end
        step();
        vectors++;
        if (AWREADY !== 1'b1 || o_count !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_ready_rise: got rdy=%b cnt=%0d want rdy=1 cnt=0", AWREADY, o_count);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        AWVALID = 1'b1;
        AWADDR  = 32'h0000_0104;
        AWPROT  = 3'b010;
        #1;
        vectors++;
        if (o_addr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_no_bypass: got valid=%b want 0", o_addr_valid);
        end
        step();
        AWVALID = 1'b0;
        AWADDR  = 32'hDEAD_BEEF;
        AWPROT  = 3'b111;
        vectors++;
        if (o_addr_valid !== 1'b1 || o_addr !== 32'h104 || o_prot !== 3'd2 || o_count !== 3'd1) begin
            miscompares++;
            $display("FAIL single_head: got v=%b addr=%h prot=%0d cnt=%0d want v=1 addr=104 prot=2 cnt=1",
                     o_addr_valid, o_addr, o_prot, o_count);
        end
        step();
        vectors++;
        if (o_count !== 3'd1 || o_addr !== 32'h104) begin
            miscompares++;
            $display("FAIL single_idle_ignored: got cnt=%0d addr=%h want cnt=1 addr=104", o_count, o_addr);
        end
        i_addr_ready = 1'b1;
        step();
        i_addr_ready = 1'b0;
        vectors++;
        if (o_count !== 3'd0 || o_addr_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pop: got cnt=%0d v=%b want cnt=0 v=0", o_count, o_addr_valid);
        end
        $display("test_single done: addr 104 prot 2");
    endtask

    task automatic test_fill_wrap();
        logic [AW-1:0] a [5];
        for (int i = 0; i < 5; i++) a[i] = 32'h0000_0201 + 32'(i * 4);
        for (int i = 0; i < 4; i++) begin
            AWVALID = 1'b1;
            AWADDR  = a[i];
            AWPROT  = 3'(i);
            step();
        end
        AWADDR = a[4];
        AWPROT = 3'd4;
        step();
        vectors++;
        if (AWREADY !== 1'b0 || o_count !== 3'd4) begin
            miscompares++;
            $display("FAIL fill_full: got rdy=%b cnt=%0d want rdy=0 cnt=4", AWREADY, o_count);
        end
        i_addr_ready = 1'b1;
        step();
        i_addr_ready = 1'b0;
        vectors++;
        if (AWREADY !== 1'b1 || o_count !== 3'd3 || o_addr !== 32'h204) begin
            miscompares++;
            $display("FAIL fill_pop_when_full: got rdy=%b cnt=%0d addr=%h want rdy=1 cnt=3 addr=204",
                     AWREADY, o_count, o_addr);
        end
        step();
        AWVALID = 1'b0;
        vectors++;
        if (o_count !== 3'd4) begin
            miscompares++;
            $display("FAIL fill_fifth_accept: got cnt=%0d want 4", o_count);
        end
        i_addr_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            vectors++;
            if (o_addr !== (32'h0000_0200 + 32'(i * 4)) || o_prot !== 3'(i)) begin
                miscompares++;
                $display("FAIL fill_order[%0d]: got addr=%h prot=%0d want addr=%h prot=%0d",
                         i, o_addr, o_prot, 32'h0000_0200 + 32'(i * 4), i);
            end
            step();
        end
        i_addr_ready = 1'b0;
        vectors++;
        if (o_count !== 3'd0) begin
            miscompares++;
            $display("FAIL fill_drain: got cnt=%0d want 0", o_count);
        end
        $display("test_fill_wrap done");
    endtask

    task automatic test_back_to_back();
        AWVALID = 1'b1;
        AWADDR  = 32'h0000_3000;
        AWPROT  = 3'd1;
        step();
        for (int i = 0; i < 16; i++) begin
            AWADDR = 32'h0000_3000 + 32'((i + 1) * 4);
            i_addr_ready = 1'b1;
            #1;
            vectors++;
            if (o_addr !== 32'h0000_3000 + 32'(i * 4) || AWREADY !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_head[%0d]: got addr=%h rdy=%b want addr=%h rdy=1",
                         i, o_addr, AWREADY, 32'h0000_3000 + 32'(i * 4));
            end
            step();
            vectors++;
            if (o_count !== 3'd1) begin
                miscompares++;
                $display("FAIL stream_count[%0d]: got %0d want 1", i, o_count);
            end
        end
        AWVALID = 1'b0;
        vectors++;
        if (o_addr !== 32'h0000_3040) begin
            miscompares++;
            $display("FAIL stream_last: got addr=%h want 00003040", o_addr);
        end
        step();
        i_addr_ready = 1'b0;
        vectors++;
        if (o_count !== 3'd0) begin
            miscompares++;
            $display("FAIL stream_drain: got cnt=%0d want 0", o_count);
        end
        $display("test_back_to_back done: 17 addresses");
    endtask

    task automatic test_range();
        logic [AW-1:0] addr_in  [4] = '{32'h0000_0FFC, 32'h0000_1000, 32'h0000_1FFF, 32'h0000_2000};
        logic [AW-1:0] addr_exp [4] = '{32'h0000_0FFC, 32'h0000_1000, 32'h0000_1FFC, 32'h0000_2000};
        logic          err_out  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            AWVALID = 1'b1;
            AWADDR  = addr_in[i];
            AWPROT  = 3'd0;
            step();
            AWVALID = 1'b0;
            vectors++;
            if (o_addr !== addr_exp[i] || o_addr_err !== (err_out[i] & RC_EN)) begin
                miscompares++;
                $display("FAIL range[%0d]: got addr=%h err=%b want addr=%h err=%b",
                         i, o_addr, o_addr_err, addr_exp[i], err_out[i] & RC_EN);
            end
            i_addr_ready = 1'b1;
            step();
            i_addr_ready = 1'b0;
            $display("range push %h -> err %b", addr_in[i], err_out[i] & RC_EN);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            AWVALID = 1'b1;
            AWADDR  = 32'h0000_5000 + 32'(i * 4);
            step();
        end
        AWVALID = 1'b0;
        vectors++;
        if (o_count !== 3'd3) begin
            miscompares++;
            $display("FAIL async_prefill: got cnt=%0d want 3", o_count);
        end
        #1;
        ARESETn = 1'b0;
        #1;
        vectors++;
        if (o_addr_valid !== 1'b0 || o_count !== 3'd0 || AWREADY !== 1'b0 || o_addr !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b cnt=%0d rdy=%b addr=%h want 0 0 0 0",
                     o_addr_valid, o_count, AWREADY, o_addr);
        end
        step();
        ARESETn = 1'b1;
        step();
        step();
        vectors++;
        if (AWREADY !== 1'b1 || o_count !== 3'd0) begin
            miscompares++;
            $display("FAIL async_recover: got rdy=%b cnt=%0d want rdy=1 cnt=0", AWREADY, o_count);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_wrap();
        test_back_to_back();
        test_range();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axil_aw_slave_fifo.md
# axil_aw_slave_fifo

Parametrised AXI4-Lite write-address channel slave. Accepts AW handshakes from a master, buffers address and protection in a DEPTH-entry first-word-fall-through queue, and presents them in order to the slave's write-data/response logic. It adds back-pressure, multiple outstanding addresses, AWPROT capture, word alignment and an optional address-range check.

## Interface
- ADDR_WIDTH, 32, AWADDR and o_addr width; legal range 12..64
- DEPTH, 4, queue entries; power of two, >= 2
- BASE_ADDR, 'h0000_0000, lowest decoded byte address; ADDR_WIDTH bits
- RANGE_SIZE, 'h1000, decoded window size in bytes; power of two
- Clock and reset: one clock; reset is asynchronous and active-low (ACLK, ARESETn).
- ACLK  in  1  clock; all logic on rising edge
- ARESETn  in  1  asynchronous active-low reset
- AWVALID  in  1  master address valid
- AWADDR  in  ADDR_WIDTH  master write address
- AWPROT  in  3  master protection attributes
- AWREADY  out  1  slave ready; driven only from registered state
- o_addr_valid  out  1  queue head valid
- o_addr  out  ADDR_WIDTH  head address, bits [1:0] forced to 0
- o_prot  out  3  head AWPROT
- o_addr_err  out  1  head address outside [BASE_ADDR, BASE_ADDR+RANGE_SIZE)
- i_addr_ready  in  1  consumer pops head when o_addr_valid && i_addr_ready
- o_count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Push: AWVALID && AWREADY at a rising edge writes {AWADDR & ~3, AWPROT, err} at the write pointer.
- Pop: o_addr_valid && i_addr_ready advances the read pointer.
- Pointers are $clog2(DEPTH) bits and wrap naturally; occupancy is a separate counter, 0..DEPTH.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- AWREADY = rst_done && (count != DEPTH). No full-bypass: when full, AWREADY stays 0 even if a pop occurs that cycle.
- No empty-bypass: a pushed entry appears on o_addr no earlier than the next cycle.
- rst_done is a flop cleared by reset and set on the first ACLK edge after ARESETn deasserts.
- Stored data is held stable while o_addr_valid && !i_addr_ready.
- AWADDR and AWPROT are sampled only on a handshake; values while AWVALID=0 are ignored.

## Timing
- Reset, asserted asynchronously: AWREADY=0, o_addr_valid=0, o_count=0, o_addr=0, o_prot=0, o_addr_err=0, pointers=0, rst_done=0.
- Reset asserted mid-operation discards all queued entries; any in-flight handshake is lost.
- After ARESETn rises, AWREADY goes 1 one edge later.
- Push-to-head latency is 1 cycle when the queue is empty.
- Sustained throughput is one address per cycle while a pop occurs every cycle.
- A master holding AWVALID with AWREADY=0 is not accepted. The slave never deasserts AWREADY because of AWVALID.

## Configuration
- AXIL_AW_RANGE_CHECK_EN defined: err is computed at push as (AWADDR - BASE_ADDR) >= RANGE_SIZE (unsigned, ADDR_WIDTH wide) and stored per entry. Downstream returns DECERR for flagged entries.
- Not defined: no err storage, o_addr_err tied to 0, BASE_ADDR and RANGE_SIZE unused.

## Structure
- Package axil_pkg holds:
  - prot_t (3-bit) typedef
  - AXIL_RESP_OKAY/SLVERR/DECERR constants
  - AXIL_WORD_MASK
- One sub-module, axil_sync_fifo: parameterised width/depth FWFT storage with count. The top wraps it with handshake, alignment, reset-release and range-check logic.

## Test plan
- Reset release, AWVALID=0: AWREADY 0 during reset and for 1 edge after, then 1; o_count=0.
- Push 'h0000_0104 with prot 3'b010, i_addr_ready=0: next cycle o_addr_valid=1, o_addr='h104, o_prot=2, o_count=1.
- Push 5 addresses with DEPTH=4 and no pops: first 4 accepted, AWREADY=0 with o_count=4. Pop one: AWREADY=1 next cycle, 5th accepted; FIFO order preserved across pointer wrap.
- Continuous push and pop for 16 cycles: one address per cycle, o_count constant at 1, addresses in order.
- With AXIL_AW_RANGE_CHECK_EN, BASE='h1000, SIZE='h1000: push 'h0FFC gives err=1, 'h1000 gives 0, 'h1FFF gives 0 (o_addr='h1FFC), 'h2000 gives 1. Without the macro, all give 0.
- ARESETn pulsed low while 3 entries are queued: o_addr_valid and o_count drop to 0 immediately, without waiting for ACLK.
